xbar_req_buffer: RTL and testbench

- Parametrised request buffer for the crossbar core: NUM_CH upstream channels, NUM_BANK downstream banks, DEPTH entries per channel.
- Owns its own entry allocation, per-bank ordering and per-bank round-robin channel arbitration, so it needs no externally supplied write pointers or one-hot read selects.
- Sits between the channel request ports and the bank pipelines, with valid/ready on both sides.

---
 rtl/xbar_req_buffer_pkg.sv | 20 ++
 rtl/xbar_req_chan_buf.sv | 107 ++++++++++
 rtl/xbar_req_buffer.sv | 127 ++++++++++++
 tb/tb_xbar_req_buffer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/xbar_req_buffer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : mpc_types                                                    |
// | Description : Shared request payload and global configuration types.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package mpc_types;

    typedef struct packed {
        logic [7:0] wbufWidth;
    } mpc_cfg_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        we;
    } channel_req_t;

endpackage
`default_nettype wire

// File: rtl/xbar_req_chan_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : xbar_req_chan_buf                                            |
// | Description : One channel's entry store, free list and per-bank index FIFOs.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module xbar_req_chan_buf
    import mpc_types::*;
#(
    parameter type         wbufWidth_t = logic,
    parameter int unsigned NUM_BANK    = 4,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned BANK_LSB    = 6,
    localparam int unsigned ENTRY_W    = $clog2(DEPTH),
    localparam int unsigned BANK_W     = $clog2(NUM_BANK),
    localparam int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  channel_req_t        req,
    input  wbufWidth_t          req_wbuf_id,
    output logic [NUM_BANK-1:0] head_valid,
    output channel_req_t        head_req     [NUM_BANK],
    output wbufWidth_t          head_wbuf_id [NUM_BANK],
    input  logic [NUM_BANK-1:0] pop,
    output logic [CNT_W-1:0]    free_cnt
);

    logic [DEPTH-1:0]   r_free;
    logic [DEPTH-1:0]   w_free_nxt;
    logic [ENTRY_W-1:0] w_alloc_idx;
    logic               w_accept;
    logic [BANK_W-1:0]  w_bank_sel;
    logic [ENTRY_W-1:0] w_head_idx   [NUM_BANK];
    channel_req_t       r_entry_req  [DEPTH];
    wbufWidth_t         r_entry_wbuf [DEPTH];

    assign req_ready  = rst_n & (|r_free);
    assign w_accept   = req_valid & req_ready;
    assign w_bank_sel = req.addr[BANK_LSB +: BANK_W];

    always_comb begin
        w_alloc_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (r_free[i]) w_alloc_idx = ENTRY_W'(i);
        end
    end

    // Allocation uses only the registered free vector, so an entry freed this
    // cycle is never handed out again until the next one.
    always_comb begin
        w_free_nxt = r_free;
        if (w_accept) w_free_nxt[w_alloc_idx] = 1'b0;
        for (int b = 0; b < NUM_BANK; b++) begin
            if (pop[b]) w_free_nxt[w_head_idx[b]] = 1'b1;
        end
    end

    always_comb begin
        free_cnt = '0;
        for (int i = 0; i < DEPTH; i++) free_cnt = free_cnt + CNT_W'(r_free[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_free <= '1;
        else        r_free <= w_free_nxt;
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_entry_req[w_alloc_idx]  <= req;
            r_entry_wbuf[w_alloc_idx] <= req_wbuf_id;
        end
    end

    for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank_fifo
        logic [ENTRY_W-1:0] r_mem [DEPTH];
        logic [ENTRY_W:0]   r_wptr;
        logic [ENTRY_W:0]   r_rptr;
        logic               w_push;

        assign w_push = w_accept && (w_bank_sel == BANK_W'(b));

        always_ff @(posedge clk) begin
            if (w_push) r_mem[r_wptr[ENTRY_W-1:0]] <= w_alloc_idx;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + 1'b1;
                if (pop[b]) r_rptr <= r_rptr + 1'b1;
            end
        end

        assign head_valid[b]   = (r_wptr != r_rptr);
        assign w_head_idx[b]   = r_mem[r_rptr[ENTRY_W-1:0]];
        assign head_req[b]     = r_entry_req[w_head_idx[b]];
        assign head_wbuf_id[b] = r_entry_wbuf[w_head_idx[b]];
    end

endmodule
`default_nettype wire

// File: rtl/xbar_req_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : xbar_req_buffer                                              |
// | Description : Channel-to-bank request buffer with per-bank RR arbitration. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module xbar_req_buffer
    import mpc_types::*;
#(
    parameter mpc_cfg_t    Cfg         = '0,
    parameter type         wbufWidth_t = logic,
    parameter int unsigned NUM_CH      = 3,
    parameter int unsigned NUM_BANK    = 4,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned BANK_LSB    = 6,
    localparam int unsigned CH_ID_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_CH-1:0]   u_ch_req_valid,
    output logic [NUM_CH-1:0]   u_ch_req_ready,
    input  channel_req_t        u_ch_req           [NUM_CH],
    input  wbufWidth_t          u_ch_req_wbuf_id   [NUM_CH],
    output logic [NUM_BANK-1:0] d_bank_req_valid,
    input  logic [NUM_BANK-1:0] d_bank_req_ready,
    output channel_req_t        d_bank_req         [NUM_BANK],
    output wbufWidth_t          d_bank_req_wbuf_id [NUM_BANK],
    output logic [CH_ID_W-1:0]  d_bank_req_ch_id   [NUM_BANK],
    output logic [CNT_W-1:0]    ch_free_cnt        [NUM_CH]
);

    if (int'(Cfg.wbufWidth) > $bits(wbufWidth_t)) begin : g_cfg_check
        $error("wbufWidth_t is narrower than Cfg.wbufWidth");
    end

    logic [NUM_BANK-1:0] w_head_valid [NUM_CH];
    channel_req_t        w_head_req   [NUM_CH][NUM_BANK];
    wbufWidth_t          w_head_wbuf  [NUM_CH][NUM_BANK];
    logic [NUM_BANK-1:0] w_pop        [NUM_CH];
    logic [CH_ID_W-1:0]  w_gnt        [NUM_BANK];
    logic [NUM_BANK-1:0] w_valid;
    logic [NUM_BANK-1:0] w_hs;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        xbar_req_chan_buf #(
            .wbufWidth_t (wbufWidth_t),
            .NUM_BANK    (NUM_BANK),
            .DEPTH       (DEPTH),
            .BANK_LSB    (BANK_LSB)
        ) u_chan_buf (
            .clk          (clk),
            .rst_n        (rst_n),
            .req_valid    (u_ch_req_valid[c]),
            .req_ready    (u_ch_req_ready[c]),
            .req          (u_ch_req[c]),
            .req_wbuf_id  (u_ch_req_wbuf_id[c]),
            .head_valid   (w_head_valid[c]),
            .head_req     (w_head_req[c]),
            .head_wbuf_id (w_head_wbuf[c]),
            .pop          (w_pop[c]),
            .free_cnt     (ch_free_cnt[c])
        );
    end

    for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
        logic [NUM_CH-1:0]  w_cand;
        logic [CH_ID_W-1:0] w_rr_gnt;
        logic [CH_ID_W-1:0] r_rr_ptr;
        logic [CH_ID_W-1:0] r_lock_ch;
        logic               r_lock;

        always_comb begin
            w_cand = '0;
            for (int c = 0; c < NUM_CH; c++) w_cand[c] = w_head_valid[c][b];
        end

        always_comb begin
            logic [CH_ID_W:0] w_sum;
            logic             w_found;
            w_sum    = '0;
            w_found  = 1'b0;
            w_rr_gnt = r_rr_ptr;
            for (int k = 0; k < NUM_CH; k++) begin
                w_sum = {1'b0, r_rr_ptr} + (CH_ID_W + 1)'(k);
                if (w_sum >= (CH_ID_W + 1)'(NUM_CH)) w_sum = w_sum - (CH_ID_W + 1)'(NUM_CH);
                if (!w_found && w_cand[w_sum[CH_ID_W-1:0]]) begin
                    w_found  = 1'b1;
                    w_rr_gnt = w_sum[CH_ID_W-1:0];
                end
            end
        end

        // A stalled grant stays locked so later arrivals cannot swap the payload.
        assign w_gnt[b]   = r_lock ? r_lock_ch : w_rr_gnt;
        assign w_valid[b] = rst_n & (|w_cand);
        assign w_hs[b]    = w_valid[b] & d_bank_req_ready[b];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_rr_ptr  <= '0;
                r_lock    <= 1'b0;
                r_lock_ch <= '0;
            end else if (w_hs[b]) begin
                r_lock   <= 1'b0;
                r_rr_ptr <= (w_gnt[b] == CH_ID_W'(NUM_CH - 1)) ? '0 : w_gnt[b] + 1'b1;
            end else if (w_valid[b]) begin
                r_lock    <= 1'b1;
                r_lock_ch <= w_gnt[b];
            end
        end

        assign d_bank_req_valid[b]   = w_valid[b];
        assign d_bank_req[b]         = w_valid[b] ? w_head_req[w_gnt[b]][b] : '0;
        assign d_bank_req_wbuf_id[b] = w_valid[b] ? w_head_wbuf[w_gnt[b]][b] : '0;
        assign d_bank_req_ch_id[b]   = w_valid[b] ? w_gnt[b] : '0;
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) w_pop[c] = '0;
        for (int b = 0; b < NUM_BANK; b++) begin
            if (w_hs[b]) w_pop[w_gnt[b]][b] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_xbar_req_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_xbar_req_buffer                                           |
// | Description : Directed self-checking bench for xbar_req_buffer.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_xbar_req_buffer;
    import mpc_types::*;

    typedef logic [3:0] wbuf_t;

    logic                clk   = 1'b0;
    logic                rst_n = 1'b0;
    logic [2:0]          u_ch_req_valid;
    logic [2:0]          u_ch_req_ready;
    channel_req_t        u_ch_req           [3];
    wbuf_t               u_ch_req_wbuf_id   [3];
    logic [3:0]          d_bank_req_valid;
    logic [3:0]          d_bank_req_ready;
    channel_req_t        d_bank_req         [4];
    wbuf_t               d_bank_req_wbuf_id [4];
    logic [1:0]          d_bank_req_ch_id   [4];
    logic [3:0]          ch_free_cnt        [3];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    xbar_req_buffer #(
        .Cfg         (mpc_cfg_t'{wbufWidth: 8'd4}),
        .wbufWidth_t (wbuf_t),
        .NUM_CH      (3),
        .NUM_BANK    (4),
        .DEPTH       (8),
        .BANK_LSB    (6)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .u_ch_req_valid     (u_ch_req_valid),
        .u_ch_req_ready     (u_ch_req_ready),
        .u_ch_req           (u_ch_req),
        .u_ch_req_wbuf_id   (u_ch_req_wbuf_id),
        .d_bank_req_valid   (d_bank_req_valid),
        .d_bank_req_ready   (d_bank_req_ready),
        .d_bank_req         (d_bank_req),
        .d_bank_req_wbuf_id (d_bank_req_wbuf_id),
        .d_bank_req_ch_id   (d_bank_req_ch_id),
        .ch_free_cnt        (ch_free_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int ch, input logic [31:0] a, input logic [31:0] d, input wbuf_t w);
        u_ch_req_valid[ch]   = 1'b1;
        u_ch_req[ch]         = '{addr: a, data: d, we: 1'b1};
        u_ch_req_wbuf_id[ch] = w;
    endtask

    task automatic idle();
        u_ch_req_valid = '0;
    endtask

    initial begin
        u_ch_req_valid   = '0;
        d_bank_req_ready = '0;
        for (int c = 0; c < 3; c++) begin
            u_ch_req[c]         = '0;
            u_ch_req_wbuf_id[c] = '0;
        end

        // Reset held, then released
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", u_ch_req_ready, 3'b000);
        check("rst_valid", d_bank_req_valid, 4'b0000);
        check("rst_free0", ch_free_cnt[0], 8);
        check("rst_addr2", d_bank_req[2].addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_ready", u_ch_req_ready, 3'b111);
        check("rel_valid", d_bank_req_valid, 4'b0000);
        for (int c = 0; c < 3; c++) check("rel_free", ch_free_cnt[c], 8);

        // Fill ch0 with 8 bank-2 requests while bank 2 stalls
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            send(0, 32'h80 + 32'(i) * 32'h400, 32'h100 + 32'(i), wbuf_t'(i));
            #1;
            check("t1_ready0", u_ch_req_ready[0], 1'b1);
            if (i == 0) check("t1_no_bypass", d_bank_req_valid, 4'b0000);
            if (i == 1) check("t1_latency", d_bank_req_valid, 4'b0100);
        end
        @(negedge clk);
        idle();
        #1;
        check("t1_full_ready", u_ch_req_ready, 3'b110);
        check("t1_full_cnt0", ch_free_cnt[0], 0);
        check("t1_cnt1", ch_free_cnt[1], 8);
        check("t1_hold_valid", d_bank_req_valid, 4'b0100);
        d_bank_req_ready = 4'b0100;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            check("t1_drain_addr", d_bank_req[2].addr, 32'h80 + 32'(i) * 32'h400);
            check("t1_drain_wbuf", d_bank_req_wbuf_id[2], wbuf_t'(i));
            check("t1_drain_ch", d_bank_req_ch_id[2], 0);
            if (i == 1) begin
                check("t1_reready", u_ch_req_ready, 3'b111);
                check("t1_cnt_after1", ch_free_cnt[0], 1);
            end
        end
        @(negedge clk);
        #1;
        check("t1_empty", d_bank_req_valid, 4'b0000);
        check("t1_cnt_back", ch_free_cnt[0], 8);

        // Round robin on bank 1
        d_bank_req_ready = 4'b1111;
        @(negedge clk);
        for (int c = 0; c < 3; c++) send(c, 32'h40, 32'h200 + 32'(c), wbuf_t'(4'hA + c));
        @(negedge clk);
        idle();
        send(0, 32'h440, 32'h203, 4'hD);
        #1;
        check("t2_valid", d_bank_req_valid, 4'b0010);
        check("t2_gnt_a", d_bank_req_ch_id[1], 0);
        check("t2_data_a", d_bank_req[1].data, 32'h200);
        @(negedge clk);
        idle();
        #1;
        check("t2_gnt_b", d_bank_req_ch_id[1], 1);
        check("t2_data_b", d_bank_req[1].data, 32'h201);
        @(negedge clk);
        #1;
        check("t2_gnt_c", d_bank_req_ch_id[1], 2);
        check("t2_wbuf_c", d_bank_req_wbuf_id[1], 4'hC);
        @(negedge clk);
        #1;
        check("t2_gnt_d", d_bank_req_ch_id[1], 0);
        check("t2_addr_d", d_bank_req[1].addr, 32'h440);
        @(negedge clk);
        #1;
        check("t2_empty", d_bank_req_valid, 4'b0000);
        check("t2_cnt1", ch_free_cnt[1], 8);

        // Grant lock on bank 0
        d_bank_req_ready = 4'b1110;
        @(negedge clk);
        send(1, 32'h0, 32'h111, 4'h5);
        @(negedge clk);
        idle();
        send(0, 32'h400, 32'h222, 4'h6);
        #1;
        check("t3_valid", d_bank_req_valid[0], 1'b1);
        check("t3_ch_a", d_bank_req_ch_id[0], 1);
        check("t3_data_a", d_bank_req[0].data, 32'h111);
        @(negedge clk);
        idle();
        #1;
        check("t3_ch_b", d_bank_req_ch_id[0], 1);
        check("t3_data_b", d_bank_req[0].data, 32'h111);
        @(negedge clk);
        #1;
        check("t3_ch_c", d_bank_req_ch_id[0], 1);
        check("t3_wbuf_c", d_bank_req_wbuf_id[0], 4'h5);
        d_bank_req_ready = 4'b1111;
        @(negedge clk);
        #1;
        check("t3_ch_next", d_bank_req_ch_id[0], 0);
        check("t3_data_next", d_bank_req[0].data, 32'h222);
        @(negedge clk);
        #1;
        check("t3_empty", d_bank_req_valid, 4'b0000);

        // ch2 sweeps banks 0..3 with every bank ready
        @(negedge clk);
        send(2, 32'h0, 32'h300, 4'h0);
        #1;
        check("t4_cnt_start", ch_free_cnt[2], 8);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            send(2, 32'(k) * 32'h40, 32'h300 + 32'(k), wbuf_t'(k));
            #1;
            check("t4_valid", d_bank_req_valid, 4'(1 << (k - 1)));
            check("t4_ch", d_bank_req_ch_id[k-1], 2);
            check("t4_cnt", ch_free_cnt[2], 7);
        end
        @(negedge clk);
        idle();
        #1;
        check("t4_valid_last", d_bank_req_valid, 4'b1000);
        check("t4_data_last", d_bank_req[3].data, 32'h303);
        check("t4_cnt_last", ch_free_cnt[2], 7);
        @(negedge clk);
        #1;
        check("t4_empty", d_bank_req_valid, 4'b0000);
        check("t4_cnt_back", ch_free_cnt[2], 8);

        // Reset with five outstanding entries
        d_bank_req_ready = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            send(0, 32'hC0 + 32'(i) * 32'h400, 32'h400 + 32'(i), wbuf_t'(i));
        end
        @(negedge clk);
        idle();
        #1;
        check("t5_cnt_busy", ch_free_cnt[0], 3);
        check("t5_valid_busy", d_bank_req_valid, 4'b1000);
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", d_bank_req_valid, 4'b0000);
        check("t5_rst_ready", u_ch_req_ready, 3'b000);
        check("t5_rst_addr", d_bank_req[3].addr, 0);
        check("t5_rst_cnt", ch_free_cnt[0], 8);
        @(negedge clk);
        rst_n = 1'b1;
        d_bank_req_ready = 4'b1111;
        #1;
        check("t5_rel_ready", u_ch_req_ready, 3'b111);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("t5_no_emit", d_bank_req_valid, 4'b0000);
            check("t5_cnt", ch_free_cnt[0], 8);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
